// File: rtl/frv_exec_buffer.sv
// rtl/frv_exec_buffer.sv - two-entry execute-to-writeback skid buffer (optional forwarding port: FRV_EXEC_BUFFER_FWD_EN)
module frv_exec_buffer #(
    parameter int XLEN = 32,
    parameter int RDW  = 5
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [XLEN-1:0] s_result,
    input  logic [RDW-1:0]  s_rd,
    input  logic            s_wen,
    input  logic            flush,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_result,
    output logic [RDW-1:0]  m_rd,
    output logic            m_wen,
`ifdef FRV_EXEC_BUFFER_FWD_EN
    output logic            fwd_valid,
    output logic [RDW-1:0]  fwd_rd,
    output logic [XLEN-1:0] fwd_result,
`endif
    output logic [1:0]      occupancy
);

    localparam int         EW       = XLEN + RDW + 1;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] head_q, head_d;
    logic [EW-1:0] skid_q, skid_d;
    logic [EW-1:0] in_entry;
    logic          push, pop;

    // Entry layout {result, rd, wen}; wen is forced low for x0 so writeback never sees it.
    assign in_entry = {s_result, s_rd, s_wen && (s_rd != '0)};
    assign push     = s_valid && s_ready;
    assign pop      = m_valid && m_ready;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_TWO;
                    else if (!push && pop) state_d = ST_EMPTY;
                end
                ST_TWO:   if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        m_valid   = (state_q != ST_EMPTY);
        s_ready   = (state_q != ST_TWO);
        occupancy = state_q;
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: if (push) head_d = in_entry;
                ST_ONE: begin
                    if (push && pop) head_d = in_entry;
                    else if (push)   skid_d = in_entry;
                end
                ST_TWO:   if (pop) head_d = skid_q;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign m_result = head_q[EW-1:RDW+1];
    assign m_rd     = head_q[RDW:1];
    assign m_wen    = head_q[0];

`ifdef FRV_EXEC_BUFFER_FWD_EN
    // Youngest writing entry wins: the skid holds the newer result when both are valid.
    always_comb begin
        fwd_valid  = 1'b0;
        fwd_rd     = '0;
        fwd_result = '0;
        if (state_q == ST_TWO && skid_q[0]) begin
            fwd_valid  = 1'b1;
            fwd_rd     = skid_q[RDW:1];
            fwd_result = skid_q[EW-1:RDW+1];
        end else if (state_q != ST_EMPTY && head_q[0]) begin
            fwd_valid  = 1'b1;
            fwd_rd     = head_q[RDW:1];
            fwd_result = head_q[EW-1:RDW+1];
        end
    end
`endif

endmodule

// File: tb/tb_frv_exec_buffer.sv
// tb/tb_frv_exec_buffer.sv - self-checking bench for frv_exec_buffer
module tb_frv_exec_buffer;

    logic        g_clk, g_reset;
    logic        s_valid, s_ready, s_wen, flush;
    logic [31:0] s_result, m_result;
    logic [4:0]  s_rd, m_rd;
    logic        m_valid, m_ready, m_wen;
    logic [1:0]  occupancy;
`ifdef FRV_EXEC_BUFFER_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_result;
`endif

    frv_exec_buffer #(.XLEN(32), .RDW(5)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_result(s_result),
        .s_rd(s_rd), .s_wen(s_wen), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
        .m_rd(m_rd), .m_wen(m_wen),
`ifdef FRV_EXEC_BUFFER_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
`endif
        .occupancy(occupancy)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  rd;
        logic        w;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a FIFO of depth 2, updated from the inputs seen before the edge.
    task automatic tick();
        bit   do_push, do_pop;
        ent_t e;
        do_push = s_valid && (q.size() < 2);
        do_pop  = m_ready && (q.size() > 0);
        e.r  = s_result;
        e.rd = s_rd;
        e.w  = s_wen && (s_rd != 5'd0);
        @(posedge g_clk);
        #1;
        if (g_reset || flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd, input logic w);
        s_valid  = v;
        s_result = r;
        s_rd     = rd;
        s_wen    = w;
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        g_reset = 1'b0;
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        do_reset();
        n_tests++;
        if ({m_valid, s_ready, occupancy, m_result, m_rd, m_wen} !== {1'b0, 1'b1, 2'd0, 32'h0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got v=%0b rdy=%0b occ=%0d res=%h rd=%0d wen=%0b, want 0 1 0 0 0 0",
                     m_valid, s_ready, occupancy, m_result, m_rd, m_wen);
        end
    endtask

    task automatic test_single();
        do_reset();
        m_ready = 1'b1;
        drive(1'b1, 32'h0000_1234, 5'd5, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({m_valid, m_result, m_rd, m_wen, occupancy} !== {1'b1, 32'h0000_1234, 5'd5, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL single: got v=%0b res=%h rd=%0d wen=%0b occ=%0d, want 1 00001234 5 1 1",
                     m_valid, m_result, m_rd, m_wen, occupancy);
        end
    endtask

    task automatic test_skid();
        do_reset();
        drive(1'b1, 32'h11, 5'd1, 1'b1);
        tick();
        drive(1'b1, 32'h22, 5'd2, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({occupancy, s_ready, m_result} !== {2'd2, 1'b0, 32'h11}) begin
            n_fail++;
            $display("FAIL skid_full: got occ=%0d rdy=%0b res=%h, want 2 0 11", occupancy, s_ready, m_result);
        end
        tick();
        n_tests++;
        if (m_result !== 32'h11) begin
            n_fail++;
            $display("FAIL skid_hold: got res=%h, want 11", m_result);
        end
        m_ready = 1'b1;
        tick();
        n_tests++;
        if ({m_valid, m_result} !== {1'b1, 32'h22}) begin
            n_fail++;
            $display("FAIL skid_second: got v=%0b res=%h, want 1 22", m_valid, m_result);
        end
        tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_drain: got v=%0b, want 0", m_valid);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        drive(1'b1, 32'hAA, 5'd4, 1'b1);
        tick();
        m_ready = 1'b1;
        drive(1'b1, 32'hBB, 5'd6, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({occupancy, m_result, m_rd} !== {2'd1, 32'hBB, 5'd6}) begin
            n_fail++;
            $display("FAIL push_pop: got occ=%0d res=%h rd=%0d, want 1 bb 6", occupancy, m_result, m_rd);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h1, 5'd1, 1'b1);
        tick();
        drive(1'b1, 32'h2, 5'd2, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'hDEAD, 5'd9, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({occupancy, m_valid, s_ready} !== {2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush: got occ=%0d v=%0b rdy=%0b, want 0 0 1", occupancy, m_valid, s_ready);
        end
        m_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%0b res=%h, want v=0", m_valid, m_result);
        end
    endtask

    task automatic test_wen_zero_and_reset();
        do_reset();
        drive(1'b1, 32'h55, 5'd0, 1'b1);
        tick();
        n_tests++;
        if ({m_valid, m_wen} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wen_x0: got v=%0b wen=%0b, want 1 0", m_valid, m_wen);
        end
        drive(1'b1, 32'h66, 5'd7, 1'b1);
        tick();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({m_valid, s_ready, occupancy, m_result, m_rd, m_wen} !== {1'b0, 1'b1, 2'd0, 32'h0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_two: got v=%0b rdy=%0b occ=%0d res=%h rd=%0d wen=%0b, want 0 1 0 0 0 0",
                     m_valid, s_ready, occupancy, m_result, m_rd, m_wen);
        end
    endtask

`ifdef FRV_EXEC_BUFFER_FWD_EN
    task automatic test_fwd();
        do_reset();
        drive(1'b1, 32'h33, 5'd3, 1'b1);
        tick();
        drive(1'b1, 32'h77, 5'd7, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({fwd_valid, fwd_rd, fwd_result} !== {1'b1, 5'd7, 32'h77}) begin
            n_fail++;
            $display("FAIL fwd_skid: got v=%0b rd=%0d res=%h, want 1 7 77", fwd_valid, fwd_rd, fwd_result);
        end
        do_reset();
        drive(1'b1, 32'h33, 5'd3, 1'b1);
        tick();
        drive(1'b1, 32'h77, 5'd7, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if ({fwd_valid, fwd_rd, fwd_result} !== {1'b1, 5'd3, 32'h33}) begin
            n_fail++;
            $display("FAIL fwd_head: got v=%0b rd=%0d res=%h, want 1 3 33", fwd_valid, fwd_rd, fwd_result);
        end
    endtask
`endif

    task automatic test_random();
        logic        hold;
        logic [37:0] prev;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            g_reset = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 24) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)), 1'($urandom));
            hold = (q.size() > 0) && !m_ready && !flush && !g_reset;
            prev = {m_result, m_rd, m_wen};
            tick();
            n_tests++;
            if ({occupancy, m_valid, s_ready} !== {2'(q.size()), q.size() != 0, q.size() != 2}) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got occ=%0d v=%0b rdy=%0b, want occ=%0d", i,
                         occupancy, m_valid, s_ready, q.size());
            end
            if (q.size() > 0) begin
                n_tests++;
                if ({m_result, m_rd, m_wen} !== {q[0].r, q[0].rd, q[0].w}) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got %h/%0d/%0b, want %h/%0d/%0b", i,
                             m_result, m_rd, m_wen, q[0].r, q[0].rd, q[0].w);
                end
            end
            if (hold) begin
                n_tests++;
                if ({m_result, m_rd, m_wen} !== prev) begin
                    n_fail++;
                    $display("FAIL rand_stable[%0d]: got %h, want %h", i, {m_result, m_rd, m_wen}, prev);
                end
            end
        end
        g_reset = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        g_reset = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        test_reset();
        test_single();
        test_skid();
        test_push_pop();
        test_flush();
        test_wen_zero_and_reset();
`ifdef FRV_EXEC_BUFFER_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frv_exec_buffer.md
FRV_EXEC_BUFFER -- requirements
Module: frv_exec_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; XL = XLEN-1.
REQ-002 SHALL have parameter RDW, default 5, destination register index width.
REQ-003 SHALL have port g_clk  input  1  global clock; all state on rising edge.
REQ-004 SHALL have port g_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s_valid  input  1  execute stage presents a result.
REQ-006 SHALL have port s_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port s_result  input  XLEN  execute result (ALU/adder/compare output).
REQ-008 SHALL have port s_rd  input  RDW  destination register index.
REQ-009 SHALL have port s_wen  input  1  result to be written back.
REQ-010 SHALL have port flush  input  1  discard all buffered and incoming entries.
REQ-011 SHALL have port m_valid  output  1  head entry valid towards writeback.
REQ-012 SHALL have port m_ready  input  1  writeback consumes head.
REQ-013 SHALL have port m_result  output  XLEN  head result.
REQ-014 SHALL have port m_rd  output  RDW  head destination index.
REQ-015 SHALL have port m_wen  output  1  head write enable.
REQ-016 SHALL have port occupancy  output  2  entries held, 0..2.

Function
REQ-020 SHALL hold two entries: head (drives m_*) and skid; state EMPTY(0), ONE(1), TWO(2), equal to occupancy.
REQ-021 SHALL accept (push) when s_valid && s_ready; SHALL pop when m_valid && m_ready.
REQ-022 SHALL drive m_valid = (occupancy != 0) and s_ready = (occupancy != 2), both from registered state only, no input-to-output combinational path.
REQ-023 SHALL present an accepted entry on m_* exactly 1 cycle after acceptance when buffer was EMPTY or popping; no same-cycle bypass.
REQ-024 EMPTY: push -> ONE, head <= input; otherwise stay EMPTY.
REQ-025 ONE: push and pop -> ONE, head <= input; push only -> TWO, skid <= input; pop only -> EMPTY; neither -> ONE.
REQ-026 TWO: pop -> ONE, head <= skid; no pop -> TWO; push cannot occur (s_ready=0).
REQ-027 m_result, m_rd, m_wen SHALL remain stable while m_valid && !m_ready.
REQ-028 SHALL store wen as s_wen && (s_rd != 0); m_wen SHALL never be 1 with m_rd == 0.
REQ-029 flush SHALL set next state EMPTY regardless of push/pop that cycle; a simultaneous push is dropped; m_valid=0 and s_ready=1 the following cycle.
REQ-030 Entries SHALL leave in acceptance order; no entry duplicated or lost except by flush or reset.

Reset
REQ-040 While g_reset=1 at a clock edge, next state SHALL be EMPTY: m_valid=0, s_ready=1, occupancy=0, head/skid payload=0, m_result=0, m_rd=0, m_wen=0.
REQ-041 Reset SHALL take priority over flush, push and pop; reset mid-operation discards all entries.

Configuration
REQ-050 With macro FRV_EXEC_BUFFER_FWD_EN defined, SHALL add outputs fwd_valid (1), fwd_rd (RDW), fwd_result (XLEN): youngest valid entry with stored wen=1 (skid if TWO and skid wen=1, else head if head wen=1), registered-state only; fwd_valid=0 when none; all 0 in reset.
REQ-051 Without FRV_EXEC_BUFFER_FWD_EN, fwd_* ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-060 Reset then s_valid=1, s_result=0x0000_1234, s_rd=5, s_wen=1, m_ready=1 -> next cycle m_valid=1, m_result=0x0000_1234, m_rd=5, m_wen=1, occupancy=1.
REQ-061 m_ready=0, push A=0x11 then B=0x22 -> occupancy=2, s_ready=0, m_result=0x11 held stable; m_ready=1 -> 0x11 then 0x22 on consecutive cycles, then m_valid=0.
REQ-062 ONE with head 0xAA, simultaneous push 0xBB and pop -> occupancy stays 1, m_result=0xBB next cycle.
REQ-063 TWO state, flush=1 with s_valid=1 -> next cycle occupancy=0, m_valid=0, s_ready=1, dropped entry never appears.
REQ-064 Push s_rd=0, s_wen=1 -> m_wen=0; g_reset=1 while TWO -> all outputs 0, s_ready=1 next cycle.
REQ-065 FRV_EXEC_BUFFER_FWD_EN defined, head rd=3 wen=1, skid rd=7 wen=1 -> fwd_valid=1, fwd_rd=7; skid wen=0 -> fwd_rd=3.
